// File: rtl/locked_register_reader.sv
// Read-side access controller for the lock-protected register bank.
// Serves four-phase read requests, grants or masks each read according to the
// register lock bit and requester trust, and counts denied reads.
// Optional feature macro: LOCKED_READER_ALARM_EN (sticky alarm with read lockout).
module locked_register_reader #(
  parameter int unsigned          DATA_W       = 16,
  parameter int unsigned          NUM_REGS     = 4,
  parameter int unsigned          ADDR_W       = 2,
  parameter logic [DATA_W-1:0]    MASK_VALUE   = '0,
  parameter int unsigned          VIOL_W       = 8,
  parameter logic [VIOL_W-1:0]    ALARM_THRESH = VIOL_W'(4)
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       trusted,
  input  logic                       debug_mode,
  input  logic [NUM_REGS-1:0]        lock_status,
  input  logic [NUM_REGS*DATA_W-1:0] reg_data,
  output logic                       rd_ack,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_err,
  output logic [VIOL_W-1:0]          viol_count,
  output logic                       alarm
);

  typedef enum logic [1:0] {StIdle, StCheck, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                trusted_q, trusted_d;
  logic                debug_q, debug_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [VIOL_W-1:0]   viol_q, viol_d;

  logic                sel_valid;
  logic                sel_lock;
  logic [DATA_W-1:0]   sel_data;
  logic                lockout;
  logic                deny;

  // Debug mode is recorded with the request but never grants access on its own.
  logic unused_debug;
  assign unused_debug = debug_q;

  // Decode the captured address against the live lock bits and register contents.
  always_comb begin
    sel_valid = 1'b0;
    sel_lock  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (addr_q == ADDR_W'(i)) begin
        sel_valid = 1'b1;
        sel_lock  = lock_status[i];
        sel_data  = reg_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign deny = !sel_valid || (sel_lock && !trusted_q) || lockout;

  // Next-state logic and response/counter updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    trusted_d = trusted_q;
    debug_d   = debug_q;
    ack_d     = ack_q;
    data_d    = data_q;
    err_d     = err_q;
    viol_d    = viol_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          addr_d    = rd_addr;
          trusted_d = trusted;
          debug_d   = debug_mode;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        if (deny) begin
          data_d = MASK_VALUE;
          err_d  = 1'b1;
          if (viol_q != '1) viol_d = viol_q + VIOL_W'(1);
        end else begin
          data_d = sel_data;
          err_d  = 1'b0;
        end
        // An aborted request still records its check result, just without an ack.
        if (rd_req) begin
          ack_d   = 1'b1;
          state_d = StResp;
        end else begin
          state_d = StIdle;
        end
      end
      StResp: begin
        if (!rd_req) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and response registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      trusted_q <= 1'b0;
      debug_q   <= 1'b0;
      ack_q     <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      viol_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      trusted_q <= trusted_d;
      debug_q   <= debug_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      err_q     <= err_d;
      viol_q    <= viol_d;
    end
  end

`ifdef LOCKED_READER_ALARM_EN
  logic alarm_q, alarm_d;

  // Alarm latches once the violation count reaches the threshold.
  always_comb begin
    alarm_d = alarm_q | (viol_d >= ALARM_THRESH);
  end

  // Sticky alarm register, cleared only by reset.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= alarm_d;
  end

  assign lockout = alarm_q;
  assign alarm   = alarm_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^ALARM_THRESH;
  assign lockout       = 1'b0;
  assign alarm         = 1'b0;
`endif

  assign rd_ack     = ack_q;
  assign rd_data    = data_q;
  assign rd_err     = err_q;
  assign viol_count = viol_q;

endmodule

// File: tb/tb_locked_register_reader.sv
// Self-checking bench for locked_register_reader: two instances (default
// configuration and a small one with 3 registers, 2-bit counter and a non-zero
// mask) share one stimulus stream and are compared against a behavioural model.
module tb_locked_register_reader;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic        trusted = 1'b0;
  logic        debug_mode = 1'b0;
  logic [3:0]  lock = '0;
  logic [15:0] reg_arr [4];
  logic [63:0] reg_flat;

  logic        ack   [2];
  logic [15:0] data  [2];
  logic        err   [2];
  logic        alm   [2];
  logic [7:0]  viol0;
  logic [1:0]  viol1;

  // Model state per instance.
  int unsigned nregs [2] = '{4, 3};
  int unsigned vmax  [2] = '{255, 3};
  int unsigned thr   [2] = '{4, 3};
  logic [15:0] mask  [2] = '{16'h0000, 16'hDEAD};
  logic [15:0] m_data [2];
  logic        m_err  [2];
  int unsigned m_viol [2];
  logic        m_alarm[2];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  always_comb reg_flat = {reg_arr[3], reg_arr[2], reg_arr[1], reg_arr[0]};

  locked_register_reader dut0 (
    .Clk(Clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .trusted(trusted),
    .debug_mode(debug_mode), .lock_status(lock), .reg_data(reg_flat), .rd_ack(ack[0]),
    .rd_data(data[0]), .rd_err(err[0]), .viol_count(viol0), .alarm(alm[0])
  );

  locked_register_reader #(
    .DATA_W(16), .NUM_REGS(3), .ADDR_W(2), .MASK_VALUE(16'hDEAD), .VIOL_W(2),
    .ALARM_THRESH(2'd3)
  ) dut1 (
    .Clk(Clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .trusted(trusted),
    .debug_mode(debug_mode), .lock_status(lock[2:0]), .reg_data(reg_flat[47:0]),
    .rd_ack(ack[1]), .rd_data(data[1]), .rd_err(err[1]), .viol_count(viol1),
    .alarm(alm[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = '0; m_err[k] = 1'b0; m_viol[k] = 0; m_alarm[k] = 1'b0;
    end
  endtask

  // Access rule: out-of-range or locked-untrusted reads are denied (plus lockout).
  task automatic model_eval(input int k, input logic [1:0] a, input logic t);
    bit dn;
    dn = (int'(a) >= int'(nregs[k])) || (lock[a] && !t);
`ifdef LOCKED_READER_ALARM_EN
    dn = dn || m_alarm[k];
`endif
    if (dn) begin
      m_data[k] = mask[k];
      m_err[k]  = 1'b1;
      if (m_viol[k] < vmax[k]) m_viol[k]++;
    end else begin
      m_data[k] = reg_arr[a];
      m_err[k]  = 1'b0;
    end
`ifdef LOCKED_READER_ALARM_EN
    if (m_viol[k] >= thr[k]) m_alarm[k] = 1'b1;
`endif
  endtask

  task automatic chk_state(input string tag, input logic exp_ack);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.ack[%0d]", tag, k), 32'(ack[k]), 32'(exp_ack));
      chk($sformatf("%s.data[%0d]", tag, k), 32'(data[k]), 32'(m_data[k]));
      chk($sformatf("%s.err[%0d]", tag, k), 32'(err[k]), 32'(m_err[k]));
      chk($sformatf("%s.alarm[%0d]", tag, k), 32'(alm[k]), 32'(m_alarm[k]));
    end
    chk($sformatf("%s.viol[0]", tag), 32'(viol0), m_viol[0]);
    chk($sformatf("%s.viol[1]", tag), 32'(viol1), m_viol[1]);
  endtask

  // One four-phase read; optionally abort in CHECK or change locks during CHECK.
  task automatic read_txn(input string tag, input logic [1:0] a, input logic t,
                          input logic d, input logic abort, input logic chg,
                          input logic [3:0] nl);
    @(negedge Clk);
    rd_addr = a; trusted = t; debug_mode = d; rd_req = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) chk($sformatf("%s.ack_early[%0d]", tag, k), 32'(ack[k]), 0);
    if (chg) lock = nl;
    if (abort) rd_req = 1'b0;
    trusted = ~t;  // captured value must be used, not the live one
    for (int k = 0; k < 2; k++) model_eval(k, a, t);
    @(negedge Clk);
    chk_state({tag, ".resp"}, !abort);
    if (!abort) begin
      lock = ~lock;  // late lock change must not alter the completed response
      @(negedge Clk);
      chk_state({tag, ".held"}, 1'b1);
      rd_req = 1'b0;
      @(negedge Clk);
      chk_state({tag, ".drop"}, 1'b0);
      lock = ~lock;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) reg_arr[i] = 16'(32'h1111 * (i + 1));
    model_reset();
    #1;
    chk_state("reset_async", 1'b0);
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    chk_state("reset", 1'b0);

    lock = 4'b0000; reg_arr[2] = 16'hA5A5;
    read_txn("unlocked", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    lock = 4'b0010;
    read_txn("locked_dbg", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    reg_arr[1] = 16'h1234;
    read_txn("locked_trusted", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

    for (int i = 0; i < 5; i++)
      read_txn("saturate", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    lock = 4'b0000; reg_arr[3] = 16'h5A5A;
    read_txn("addr3", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

    reg_arr[2] = 16'hBEEF;
    read_txn("abort", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge Clk);
    chk_state("abort_idle", 1'b0);

    lock = 4'b0000;
    read_txn("lock_in_check", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);

    // Reset while in RESP: everything clears without a clock edge.
    lock = 4'b0000;
    @(negedge Clk);
    rd_addr = 2'd0; trusted = 1'b1; rd_req = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    for (int k = 0; k < 2; k++) chk($sformatf("pre_reset.ack[%0d]", k), 32'(ack[k]), 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_state("mid_reset", 1'b0);
    #1 reset = 1'b0; rd_req = 1'b0;
    reg_arr[0] = 16'h0F0F;
    read_txn("after_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) reg_arr[i] = 16'($urandom);
      lock = 4'($urandom);
      read_txn($sformatf("rand%0d", n), 2'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
